dmem_port_arbiter: RTL

- Shares the single-port data RAM between two requesters: the core datapath (load/store) and a debug/loader port.
- Sits between the datapath and the RAM, and drives the RAM address, data and write-enable pins.
- The core has priority. A saturating starvation counter guarantees that the debug port is eventually granted.
- A core that loses arbitration receives a stall so the PC can be held.

---
 rtl/dmem_port_arbiter_if.sv | 46 ++++
 rtl/dmem_port_arbiter.sv | 74 +++++++
 2 files changed

// File: rtl/dmem_port_arbiter_if.sv
// Bundle of the core, debug and RAM-side signals around the data-memory arbiter.
// The slave modport is the arbiter's view; the master modport is the requesters plus the RAM.
interface dmem_port_arbiter_if #(
  parameter int unsigned ADDR_W = 8,
  parameter int unsigned DATA_W = 32
);
  logic              core_req;
  logic              core_we;
  logic [ADDR_W-1:0] core_addr;
  logic [DATA_W-1:0] core_wdata;
  logic              core_gnt;
  logic              core_stall;
  logic              core_rvalid;
  logic [DATA_W-1:0] core_rdata;

  logic              dbg_req;
  logic              dbg_we;
  logic [ADDR_W-1:0] dbg_addr;
  logic [DATA_W-1:0] dbg_wdata;
  logic              dbg_gnt;
  logic              dbg_rvalid;
  logic [DATA_W-1:0] dbg_rdata;

  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_data;
  logic              mem_wren;
  logic [DATA_W-1:0] mem_q;

  modport master (
    output core_req, core_we, core_addr, core_wdata,
    output dbg_req, dbg_we, dbg_addr, dbg_wdata,
    output mem_q,
    input  core_gnt, core_stall, core_rvalid, core_rdata,
    input  dbg_gnt, dbg_rvalid, dbg_rdata,
    input  mem_addr, mem_data, mem_wren
  );

  modport slave (
    input  core_req, core_we, core_addr, core_wdata,
    input  dbg_req, dbg_we, dbg_addr, dbg_wdata,
    input  mem_q,
    output core_gnt, core_stall, core_rvalid, core_rdata,
    output dbg_gnt, dbg_rvalid, dbg_rdata,
    output mem_addr, mem_data, mem_wren
  );
endinterface

// File: rtl/dmem_port_arbiter.sv
// Single-port data RAM arbiter: core has priority, a saturating starvation counter
// guarantees the debug port a slot after STARVE_LIMIT consecutive denials.
module dmem_port_arbiter #(
  parameter int unsigned STARVE_LIMIT = 4
) (
  input logic                pllClk0,
  input logic                reset,
  dmem_port_arbiter_if.slave bus
);

  localparam int unsigned     CntW      = $clog2(STARVE_LIMIT + 1);
  localparam logic [CntW-1:0] StarveMax = CntW'(STARVE_LIMIT);

  typedef enum logic [1:0] {OwnNone, OwnCore, OwnDbg} owner_e;

  owner_e          owner_q;
  logic [CntW-1:0] starve_cnt_q;
  logic            core_gnt;
  logic            dbg_gnt;

  // Grants are forced low while reset is held so nothing reaches the RAM.
  always_comb begin
    dbg_gnt  = 1'b0;
    core_gnt = 1'b0;
    if (!reset) begin
      dbg_gnt  = bus.dbg_req & (~bus.core_req | (starve_cnt_q == StarveMax));
      core_gnt = bus.core_req & ~dbg_gnt;
    end
  end

  always_comb begin
    bus.mem_addr = bus.core_addr;
    bus.mem_data = bus.core_wdata;
    bus.mem_wren = 1'b0;
    if (dbg_gnt) begin
      bus.mem_addr = bus.dbg_addr;
      bus.mem_data = bus.dbg_wdata;
      bus.mem_wren = bus.dbg_we;
    end else if (core_gnt) begin
      bus.mem_wren = bus.core_we;
    end
  end

  always_ff @(posedge pllClk0 or posedge reset) begin
    if (reset) begin
      owner_q      <= OwnNone;
      starve_cnt_q <= '0;
    end else begin
      if (dbg_gnt && !bus.dbg_we) begin
        owner_q <= OwnDbg;
      end else if (core_gnt && !bus.core_we) begin
        owner_q <= OwnCore;
      end else begin
        owner_q <= OwnNone;
      end

      if (!bus.dbg_req || dbg_gnt) begin
        starve_cnt_q <= '0;
      end else if (starve_cnt_q != StarveMax) begin
        starve_cnt_q <= starve_cnt_q + CntW'(1);
      end
    end
  end

  assign bus.core_gnt    = core_gnt;
  assign bus.dbg_gnt     = dbg_gnt;
  assign bus.core_stall  = bus.core_req & ~core_gnt;
  assign bus.core_rvalid = (owner_q == OwnCore);
  assign bus.dbg_rvalid  = (owner_q == OwnDbg);
  // Both ports see the RAM output; only the valid flag says whose read it is.
  assign bus.core_rdata  = bus.mem_q;
  assign bus.dbg_rdata   = bus.mem_q;

endmodule
